// File: rtl/tmr_err_monitor.sv
// Error-event monitor for a TMR voter: counts rising edges of the mismatch flag,
// tracks the per-window event rate and raises a sticky alarm cleared by a four-phase handshake.
module tmr_err_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 1024,
    parameter int THRESH    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tmrErr,
    input  logic                 clr_req,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [7:0]           win_cnt,
    output logic                 err_sticky,
    output logic                 alarm,
    output logic                 clr_ack
);

    localparam int              TW       = $clog2(WINDOW);
    localparam logic [TW-1:0]   TMR_LAST = TW'(WINDOW - 1);
    localparam logic [7:0]      THR      = 8'(THRESH);

    typedef enum logic [1:0] {MON, ALARM, ACK} state_t;

    state_t               state_q, state_d;
    logic                 prev_q, armed_q;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [CNT_WIDTH-1:0] err_q, err_d, err_base;
    logic [7:0]           win_q, win_d, win_base;
    logic                 sticky_q, sticky_d;
    logic                 alarm_q, ack_q;
    logic                 ev, clr, wrap;

    assign err_cnt    = err_q;
    assign win_cnt    = win_q;
    assign err_sticky = sticky_q;
    assign alarm      = alarm_q;
    assign clr_ack    = ack_q;

    // armed_q masks the first edge after reset so a level held across release is not an event
    always_comb begin
        ev       = armed_q & tmrErr & ~prev_q;
        clr      = (state_q != ACK) & clr_req;
        wrap     = (tmr_q == TMR_LAST);
        tmr_d    = (clr | wrap) ? '0 : tmr_q + 1'b1;
        err_base = clr ? '0 : err_q;
        err_d    = (ev && err_base != '1) ? err_base + 1'b1 : err_base;
        win_base = (clr | wrap) ? '0 : win_q;
        win_d    = (ev && win_base != '1) ? win_base + 1'b1 : win_base;
        sticky_d = (clr ? 1'b0 : sticky_q) | ev;

        state_d = state_q;
        case (state_q)
            MON: begin
                if (clr_req)           state_d = ACK;
                else if (win_d >= THR) state_d = ALARM;
            end
            ALARM: begin
                if (clr_req) state_d = ACK;
            end
            ACK: begin
                if (!clr_req) state_d = (win_d >= THR) ? ALARM : MON;
            end
            default: state_d = MON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= MON;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            tmr_q    <= '0;
            err_q    <= '0;
            win_q    <= '0;
            sticky_q <= 1'b0;
            alarm_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= tmrErr;
            armed_q  <= 1'b1;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            win_q    <= win_d;
            sticky_q <= sticky_d;
            alarm_q  <= (state_d == ALARM);
            ack_q    <= (state_d == ACK);
        end
    end

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Randomized and directed bench for tmr_err_monitor against an integer-arithmetic reference model.
module tb_tmr_err_monitor;

    localparam int CW  = 4;
    localparam int WIN = 16;
    localparam int TH  = 3;

    logic          clk = 1'b0;
    logic          rstn, tmrErr, clr_req;
    logic [CW-1:0] err_cnt;
    logic [7:0]    win_cnt;
    logic          err_sticky, alarm, clr_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: unbounded counts, saturation applied when reported
    int m_total, m_win, m_pos;
    bit m_sticky, m_alarm, m_ack, m_prev, m_armed;

    tmr_err_monitor #(.CNT_WIDTH(CW), .WINDOW(WIN), .THRESH(TH)) dut (
        .clk(clk), .rstn(rstn), .tmrErr(tmrErr), .clr_req(clr_req),
        .err_cnt(err_cnt), .win_cnt(win_cnt), .err_sticky(err_sticky),
        .alarm(alarm), .clr_ack(clr_ack)
    );

    always #5 clk = ~clk;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ev, clr, wrap;
        if (!rstn) begin
            m_total = 0; m_win = 0; m_pos = 0;
            m_sticky = 0; m_alarm = 0; m_ack = 0; m_prev = 0; m_armed = 0;
            return;
        end
        ev      = m_armed && tmrErr && !m_prev;
        m_prev  = tmrErr;
        m_armed = 1;
        clr     = !m_ack && clr_req;
        wrap    = !clr && (m_pos == WIN - 1);
        m_pos   = clr ? 0 : (m_pos + 1) % WIN;
        if (clr) begin
            m_total = 0; m_sticky = 0;
        end
        if (clr || wrap) m_win = 0;
        if (ev) begin
            m_total++; m_win++; m_sticky = 1;
        end
        if (clr) begin
            m_ack = 1; m_alarm = 0;
        end else if (m_ack) begin
            if (!clr_req) begin
                m_ack   = 0;
                m_alarm = (min_i(m_win, 255) >= TH);
            end
        end else if (!m_alarm && min_i(m_win, 255) >= TH) begin
            m_alarm = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("err_cnt",    int'(err_cnt),    min_i(m_total, (1 << CW) - 1));
        check_eq("win_cnt",    int'(win_cnt),    min_i(m_win, 255));
        check_eq("err_sticky", int'(err_sticky), int'(m_sticky));
        check_eq("alarm",      int'(alarm),      int'(m_alarm));
        check_eq("clr_ack",    int'(clr_ack),    int'(m_ack));
    endtask

    task automatic do_reset();
        rstn = 1'b0; tmrErr = 1'b0; clr_req = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic pulse();
        tmrErr = 1'b1; tick();
        tmrErr = 1'b0; tick();
    endtask

    initial begin
        bit hold;
        rstn = 1'b0; tmrErr = 1'b0; clr_req = 1'b0;
        do_reset();
        check_eq("rst_err",    int'(err_cnt), 0);
        check_eq("rst_win",    int'(win_cnt), 0);
        check_eq("rst_alarm",  int'(alarm),   0);
        check_eq("rst_ack",    int'(clr_ack), 0);

        // single long pulse counts once
        tmrErr = 1'b1;
        repeat (5) tick();
        tmrErr = 1'b0; tick();
        check_eq("single_err",    int'(err_cnt),    1);
        check_eq("single_win",    int'(win_cnt),    1);
        check_eq("single_sticky", int'(err_sticky), 1);
        check_eq("single_alarm",  int'(alarm),      0);

        // threshold
        do_reset();
        repeat (3) pulse();
        check_eq("thr_err",   int'(err_cnt), 3);
        check_eq("thr_alarm", int'(alarm),   1);

        // clear with coincident pulse, held request, release
        clr_req = 1'b1; tmrErr = 1'b1; tick();
        check_eq("clr_err",   int'(err_cnt), 1);
        check_eq("clr_alarm", int'(alarm),   0);
        check_eq("clr_ack1",  int'(clr_ack), 1);
        tmrErr = 1'b0;
        repeat (3) tick();
        check_eq("clr_hold_err", int'(err_cnt), 1);
        clr_req = 1'b0; tick();
        check_eq("clr_ack0", int'(clr_ack), 0);

        // window wrap, including pulses landing around the wrap edge
        do_reset();
        repeat (2) pulse();
        repeat (9) tick();
        repeat (2) pulse();
        repeat (20) tick();
        for (int k = 0; k < 20; k++) begin
            tmrErr = 1'b1; tick();
            tmrErr = 1'b0; repeat (k % 4 + 1) tick();
        end

        // saturation
        do_reset();
        repeat (20) pulse();
        check_eq("sat_err", int'(err_cnt), 15);

        // reset mid-handshake with tmrErr held across release
        clr_req = 1'b1; tick();
        check_eq("ack_before_rst", int'(clr_ack), 1);
        rstn = 1'b0; tmrErr = 1'b1; tick();
        check_eq("midack_ack", int'(clr_ack), 0);
        check_eq("midack_err", int'(err_cnt), 0);
        rstn = 1'b1; clr_req = 1'b0;
        repeat (3) tick();
        check_eq("rel_err",    int'(err_cnt),    0);
        check_eq("rel_sticky", int'(err_sticky), 0);
        tmrErr = 1'b0; tick();

        // random soak
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            tmrErr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) hold = !hold;
            clr_req = hold;
            rstn = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
